sram_serial_host: RTL and testbench

SRAM_SERIAL_HOST -- requirements
Module: sram_serial_host

---
 rtl/sram_serial_host.sv | 162 ++++++++++++++++
 tb/tb_sram_serial_host.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_serial_host.sv
// Host-side controller for a serially loaded SRAM.
// A write shifts the word MSB first into an external SIPO, strobes the parallel
// load, then pulses w_en. A read holds r_en until data_valid or a timeout.
// Every command finishes with a single-cycle rsp_valid pulse.
module sram_serial_host #(
    parameter int COLS       = 8,
    parameter int ROWS       = 16,
    parameter int RD_TIMEOUT = 15,
    localparam int AW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [COLS-1:0] cmd_wdata,
    output logic            rsp_valid,
    output logic [COLS-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            serial_in,
    output logic            shift,
    output logic            load,
    output logic            w_en,
    output logic            r_en,
    output logic [AW-1:0]   addr,
    input  logic            data_valid,
    input  logic [COLS-1:0] data_out
);

    localparam int BW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TW = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LOAD,
        WRITE,
        READ,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [AW-1:0]   addr_q;
    logic [COLS-1:0] sreg;
    logic [BW-1:0]   bit_cnt;
    logic [TW-1:0]   rd_cnt;
    logic [COLS-1:0] rdata_q;
    logic            err_q;

    logic            accept;
    logic            last_bit;
    logic            rd_timeout;

    assign accept     = (state == IDLE) && cmd_valid;
    assign last_bit   = (bit_cnt == BW'(COLS - 1));
    assign rd_timeout = (rd_cnt == TW'(RD_TIMEOUT));

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state strobes; everything defaults low
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        shift      = 1'b0;
        load       = 1'b0;
        w_en       = 1'b0;
        r_en       = 1'b0;
        serial_in  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                // The write/read choice is kept by the state path itself,
                // so no separate latched direction bit is needed.
                if (cmd_valid) begin
                    state_next = cmd_write ? SHIFT : READ;
                end
            end
            SHIFT: begin
                shift     = 1'b1;
                serial_in = sreg[COLS-1];
                if (last_bit) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load       = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                w_en       = 1'b1;
                state_next = RESP;
            end
            READ: begin
                r_en = 1'b1;
                if (data_valid || rd_timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command latch, bit/timeout counters and response registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            addr_q  <= '0;
            sreg    <= '0;
            bit_cnt <= '0;
            rd_cnt  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                sreg    <= cmd_wdata;
                bit_cnt <= '0;
                rd_cnt  <= '0;
            end
            if (state == SHIFT) begin
                // Shifting left keeps the next outgoing bit at the MSB.
                sreg    <= {sreg[COLS-2:0], 1'b0};
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (state == WRITE) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (state == READ) begin
                rd_cnt <= rd_cnt + TW'(1);
                if (data_valid) begin
                    rdata_q <= data_out;
                    err_q   <= 1'b0;
                end else if (rd_timeout) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign addr      = addr_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_sram_serial_host.sv
// Directed bench for sram_serial_host with a small SIPO + SRAM model.
module tb_sram_serial_host;

    localparam int RD_TO = 15;

    logic       clk;
    logic       arst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       serial_in;
    logic       shift;
    logic       load;
    logic       w_en;
    logic       r_en;
    logic [3:0] addr;
    logic       data_valid;
    logic [7:0] data_out;

    int checks;
    int failures;

    typedef struct {
        bit         wr;
        logic [3:0] a;
        logic [7:0] d;
        int         dv;      // READ-cycle index where data_valid is raised; -1 = never
        logic [7:0] exp_rd;
        bit         exp_err;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] shadow[16];

    // SIPO + SRAM model driven by the DUT's serial interface
    logic [7:0] sipo;
    logic [7:0] sipo_q;
    logic [7:0] mem[16];

    sram_serial_host #(
        .COLS(8),
        .ROWS(16),
        .RD_TIMEOUT(RD_TO)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .serial_in(serial_in),
        .shift(shift),
        .load(load),
        .w_en(w_en),
        .r_en(r_en),
        .addr(addr),
        .data_valid(data_valid),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (shift) sipo <= {sipo[6:0], serial_in};
        if (load)  sipo_q <= sipo;
        if (w_en)  mem[addr] <= sipo_q;
    end

    function automatic vec_t mk(bit wr, logic [3:0] a, logic [7:0] d, int dv,
                                logic [7:0] rd, bit err);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.dv = dv; v.exp_rd = rd; v.exp_err = err;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one command from IDLE and follow it cycle by cycle until back in IDLE
    task automatic run_cmd(input vec_t v);
        int  i;
        bit  done;
        @(negedge clk);
        chk1("ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.a;
        cmd_wdata = v.d;
        @(negedge clk);
        // Scramble the command bus; the DUT must work from its latched copy
        cmd_valid = 1'b0;
        cmd_write = ~v.wr;
        cmd_addr  = ~v.a;
        cmd_wdata = ~v.d;
        if (v.wr) begin
            for (int k = 0; k < 8; k++) begin
                chk1("shift_hi", shift, 1'b1);
                chk1("serial_bit", serial_in, v.d[7-k]);
                chk1("busy_shift", cmd_ready, 1'b0);
                chk1("no_load_in_shift", load, 1'b0);
                @(negedge clk);
            end
            chk1("load_hi", load, 1'b1);
            chk1("load_shift_lo", shift, 1'b0);
            chk1("load_serial_lo", serial_in, 1'b0);
            @(negedge clk);
            chk1("wen_hi", w_en, 1'b1);
            chk8("wen_addr", {4'b0, addr}, {4'b0, v.a});
            @(negedge clk);
        end else begin
            i = 0;
            done = 1'b0;
            while (!done) begin
                chk1("ren_hi", r_en, 1'b1);
                chk8("ren_addr", {4'b0, addr}, {4'b0, v.a});
                chk1("no_rsp_in_read", rsp_valid, 1'b0);
                data_valid = (v.dv == i);
                data_out   = (v.dv == i) ? mem[v.a] : 8'h5A;
                if (v.dv == i || i == RD_TO) done = 1'b1;
                @(negedge clk);
                i++;
            end
            data_valid = 1'b0;
            data_out   = 8'h00;
            chk1("ren_lo_resp", r_en, 1'b0);
        end
        chk1("rsp_valid", rsp_valid, 1'b1);
        chk8("rsp_rdata", rsp_rdata, v.exp_rd);
        chk1("rsp_err", rsp_err, v.exp_err);
        @(negedge clk);
        chk1("rsp_pulse_end", rsp_valid, 1'b0);
        chk1("ready_after", cmd_ready, 1'b1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        arst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        data_valid = 1'b0;
        data_out = '0;

        vecs[0] = mk(1'b1, 4'd3,  8'hA5, -1, 8'h00, 1'b0);
        vecs[1] = mk(1'b0, 4'd3,  8'h00,  2, 8'hA5, 1'b0);
        vecs[2] = mk(1'b0, 4'd5,  8'h00, -1, 8'h00, 1'b1);
        vecs[3] = mk(1'b1, 4'd7,  8'h3C, -1, 8'h00, 1'b0);
        vecs[4] = mk(1'b0, 4'd7,  8'h00, 15, 8'h3C, 1'b0);
        vecs[5] = mk(1'b0, 4'd3,  8'h00,  0, 8'hA5, 1'b0);
        vecs[6] = mk(1'b1, 4'd12, 8'h96, -1, 8'h00, 1'b0);
        vecs[7] = mk(1'b0, 4'd12, 8'h00, 14, 8'h96, 1'b0);
        vecs[8] = mk(1'b0, 4'd7,  8'h00,  5, 8'h3C, 1'b0);

        #1;
        chk1("rst_ready", cmd_ready, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk8("rst_rdata", rsp_rdata, 8'h00);
        chk1("rst_err", rsp_err, 1'b0);
        chk1("rst_shift", shift, 1'b0);
        chk1("rst_wen", w_en, 1'b0);
        chk1("rst_ren", r_en, 1'b0);
        chk8("rst_addr", {4'b0, addr}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;

        for (int n = 0; n < 9; n++) run_cmd(vecs[n]);

        // data_valid while idle must not start anything or disturb held response
        @(negedge clk);
        data_valid = 1'b1;
        data_out = 8'h77;
        @(negedge clk);
        data_valid = 1'b0;
        data_out = 8'h00;
        chk1("dv_idle_no_rsp", rsp_valid, 1'b0);
        chk1("dv_idle_ready", cmd_ready, 1'b1);
        chk8("dv_idle_hold", rsp_rdata, 8'h3C);

        // Back-to-back writes with cmd_valid held high
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr = 4'd0;
        cmd_wdata = 8'hFF;
        @(negedge clk);
        cmd_addr = 4'd15;
        cmd_wdata = 8'h00;
        for (int c = 1; c <= 10; c++) begin
            chk1("b2b_busy", cmd_ready, 1'b0);
            chk1("b2b_no_rsp", rsp_valid, 1'b0);
            if (c <= 8) chk1("b2b_first_bits", serial_in, 1'b1);
            @(negedge clk);
        end
        chk1("b2b_rsp1", rsp_valid, 1'b1);
        chk1("b2b_busy_resp", cmd_ready, 1'b0);
        @(negedge clk);
        chk1("b2b_ready2", cmd_ready, 1'b1);
        chk1("b2b_rsp1_end", rsp_valid, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk1("b2b2_shift", shift, 1'b1);
            chk1("b2b2_bit", serial_in, 1'b0);
            @(negedge clk);
        end
        chk1("b2b2_load", load, 1'b1);
        @(negedge clk);
        chk1("b2b2_wen", w_en, 1'b1);
        chk8("b2b2_addr", {4'b0, addr}, 8'h0F);
        @(negedge clk);
        chk1("b2b2_rsp", rsp_valid, 1'b1);
        @(negedge clk);
        run_cmd(mk(1'b0, 4'd0,  8'h00, 3, 8'hFF, 1'b0));
        run_cmd(mk(1'b0, 4'd15, 8'h00, 1, 8'h00, 1'b0));

        // Reset in the fifth SHIFT cycle aborts the write
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr = 4'd9;
        cmd_wdata = 8'hFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        chk1("pre_rst_shift", shift, 1'b1);
        arst_n = 1'b0;
        #1;
        chk1("mid_rst_shift", shift, 1'b0);
        chk1("mid_rst_serial", serial_in, 1'b0);
        chk1("mid_rst_ready", cmd_ready, 1'b1);
        chk1("mid_rst_rsp", rsp_valid, 1'b0);
        chk8("mid_rst_addr", {4'b0, addr}, 8'h00);
        chk8("mid_rst_rdata", rsp_rdata, 8'h00);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            chk1("post_rst_no_rsp", rsp_valid, 1'b0);
            chk1("post_rst_ready", cmd_ready, 1'b1);
        end

        // Write all addresses with random data, then read every one back
        for (int a = 0; a < 16; a++) begin
            shadow[a] = 8'($urandom_range(0, 255));
            run_cmd(mk(1'b1, 4'(a), shadow[a], -1, 8'h00, 1'b0));
        end
        for (int a = 0; a < 16; a++) begin
            run_cmd(mk(1'b0, 4'(a), 8'h00, a % 4, shadow[a], 1'b0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
